// File: rtl/csr_intc.sv
// Machine-mode CSR file with interrupt controller: trap entry/return, WFI hold,
// and 64-bit cycle/instret counters.
module csr_intc #(
    parameter int          NUM_IRQ  = 4,
    parameter logic [31:0] ISR_BASE = 32'h0001_0000,
    parameter int          VECTORED = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               csr_valid,
    input  logic [1:0]         csr_op,
    input  logic [11:0]        csr_addr,
    input  logic [31:0]        csr_wdata,
    input  logic               mret,
    input  logic               wfi,
    input  logic [31:0]        pc,
    input  logic               stall,
    input  logic               retire,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               timer_irq,
    output logic [31:0]        csr_rdata,
    output logic               trap_take,
    output logic [31:0]        trap_pc,
    output logic [31:0]        ret_pc,
    output logic               wfi_stall
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;
    localparam logic [11:0] A_MINSTRH  = 12'hB82;

    localparam logic [31:0] MIE_MASK = (((32'd1 << NUM_IRQ) - 32'd1) << 16) | 32'h0000_0880;
    localparam logic        VEC_MODE = (VECTORED != 0);

    logic               st_mie;
    logic               st_mpie;
    logic [31:0]        mie_q;
    logic [31:0]        mepc_q;
    logic [31:0]        mcause_q;
    logic [63:0]        mcycle_q;
    logic [63:0]        minstret_q;
    logic [63:0]        mcycle_n;
    logic [63:0]        minstret_n;
    logic [31:0]        mip_v;
    logic [NUM_IRQ-1:0] ext_pend;
    logic               tmr_pend;
    logic               any_pend;
    logic [4:0]         cause;
    logic [31:0]        wval;
    logic               csr_we;
    logic               mret_en;
    logic               wfi_en;

    assign mip_v    = (32'(irq) << 16) | {20'd0, |irq, 3'd0, timer_irq, 7'd0};
    // An external source needs both its own enable and the global MEIE.
    assign ext_pend = irq & mie_q[16 +: NUM_IRQ] & {NUM_IRQ{mie_q[11]}};
    assign tmr_pend = timer_irq & mie_q[7];
    assign any_pend = (|ext_pend) | tmr_pend;

    always_comb begin
        cause = 5'd7;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (ext_pend[i]) cause = 5'(16 + i);
        end
    end

    assign trap_take = st_mie & any_pend & ~stall;
    assign trap_pc   = VEC_MODE ? (ISR_BASE + {25'd0, cause, 2'b00}) : ISR_BASE;
    assign ret_pc    = mepc_q;

    always_comb begin
        csr_rdata = 32'd0;
        case (csr_addr)
            A_MSTATUS:  csr_rdata = {19'd0, 2'b11, 3'd0, st_mpie, 3'd0, st_mie, 3'd0};
            A_MIE:      csr_rdata = mie_q;
            A_MTVEC:    csr_rdata = ISR_BASE | {31'd0, VEC_MODE};
            A_MEPC:     csr_rdata = mepc_q;
            A_MCAUSE:   csr_rdata = mcause_q;
            A_MIP:      csr_rdata = mip_v;
            A_MCYCLE:   csr_rdata = mcycle_q[31:0];
            A_MCYCLEH:  csr_rdata = mcycle_q[63:32];
            A_MINSTRET: csr_rdata = minstret_q[31:0];
            A_MINSTRH:  csr_rdata = minstret_q[63:32];
            default:    csr_rdata = 32'd0;
        endcase
    end

    always_comb begin
        case (csr_op)
            2'b01:   wval = csr_wdata;
            2'b10:   wval = csr_rdata | csr_wdata;
            2'b11:   wval = csr_rdata & ~csr_wdata;
            default: wval = csr_rdata;
        endcase
    end

    // Set/clear with a zero operand is a pure read.
    assign csr_we  = csr_valid & ~stall & ~trap_take &
                     ((csr_op == 2'b01) | (csr_op[1] & (csr_wdata != 32'd0)));
    assign mret_en = mret & ~stall & ~trap_take;
    assign wfi_en  = wfi & ~stall & ~trap_take;

    always_comb begin
        mcycle_n   = mcycle_q + 64'd1;
        minstret_n = minstret_q + 64'(retire & ~stall & ~wfi_stall);
        if (csr_we && csr_addr == A_MCYCLE)   mcycle_n[31:0]    = wval;
        if (csr_we && csr_addr == A_MCYCLEH)  mcycle_n[63:32]   = wval;
        if (csr_we && csr_addr == A_MINSTRET) minstret_n[31:0]  = wval;
        if (csr_we && csr_addr == A_MINSTRH)  minstret_n[63:32] = wval;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_mie     <= 1'b0;
            st_mpie    <= 1'b0;
            mie_q      <= 32'd0;
            mepc_q     <= 32'd0;
            mcause_q   <= 32'd0;
            mcycle_q   <= 64'd0;
            minstret_q <= 64'd0;
            wfi_stall  <= 1'b0;
        end else begin
            mcycle_q   <= mcycle_n;
            minstret_q <= minstret_n;
            if (trap_take) begin
                mepc_q   <= pc & ~32'h3;
                mcause_q <= {1'b1, 26'd0, cause};
                st_mpie  <= st_mie;
                st_mie   <= 1'b0;
            end else if (mret_en) begin
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
            end else if (csr_we) begin
                case (csr_addr)
                    A_MSTATUS: begin
                        st_mie  <= wval[3];
                        st_mpie <= wval[7];
                    end
                    A_MIE:    mie_q    <= wval & MIE_MASK;
                    A_MEPC:   mepc_q   <= wval & ~32'h3;
                    A_MCAUSE: mcause_q <= wval;
                    default:  ;
                endcase
            end
            // Wake-up ignores both MIE and stall.
            if (wfi_stall) begin
                if (any_pend) wfi_stall <= 1'b0;
            end else if (wfi_en && !any_pend) begin
                wfi_stall <= 1'b1;
            end
        end
    end

endmodule
